// File: rtl/sched_pkg.sv
// sched_pkg
//   Definitions shared by the sporadic task source and the two-machine
//   scheduler benchmarks:
//     state_t              FSM state encoding (IDLE, WAIT_ACK, ERR)
//     TASK_A / TASK_B      task-type indices into per-type vectors
//     DEFAULT_MIN_GAP      default minimum tick spacing between same-type releases
//     DEFAULT_ACK_TIMEOUT  default cycles allowed for the scheduler to ack
package sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int TASK_A = 0;
  localparam int TASK_B = 1;

  localparam int DEFAULT_MIN_GAP     = 3;
  localparam int DEFAULT_ACK_TIMEOUT = 2;

endpackage

// File: rtl/sporadic_task_source_gap_counter.sv
// gap_counter
//   Saturating up-counter that tracks how many ticks have been emitted since
//   the last release of one task type.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset, loads RESET_VAL
//     clr    synchronous clear to zero (wins over inc)
//     inc    count up by one, holding at the all-ones maximum
//     count  current counter value
module gap_counter #(
  parameter int GAP_W     = 4,
  parameter int RESET_VAL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [GAP_W-1:0] count
);

  logic [GAP_W-1:0] count_q;
  logic [GAP_W-1:0] count_d;

  // Next count: clear has priority; increment stops at the maximum so a long
  // idle stretch never wraps back below the release threshold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {GAP_W{1'b1}})) begin
      count_d = count_q + GAP_W'(1);
    end
  end

  // Reset preloads RESET_VAL so the very first release is not held off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= GAP_W'(RESET_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sporadic_task_source.sv
// sporadic_task_source
//   Environment-side generator for the two-machine scheduling benchmarks.
//   Converts free environment choices into legal sporadic releases: at most
//   one pulse per cycle, a minimum tick spacing per task type, one outstanding
//   instance per type, and an ack handshake with a sticky error on violations.
//   Ports:
//     clk, rst_n             clock and synchronous active-low reset
//     env_a, env_b, env_tick environment requests (dropped when ineligible)
//     sched_ack              scheduler accepted the most recent release
//     task_done_a/_b         completion reports from the machines
//     startA, startB, tick   registered single-cycle, mutually exclusive pulses
//     busy_a, busy_b         outstanding-instance flags
//     error                  sticky protocol-violation flag
module sporadic_task_source
  import sched_pkg::*;
#(
  parameter int MIN_GAP     = DEFAULT_MIN_GAP,
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter int GAP_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic env_a,
  input  logic env_b,
  input  logic env_tick,
  input  logic sched_ack,
  input  logic task_done_a,
  input  logic task_done_b,
  output logic startA,
  output logic startB,
  output logic tick,
  output logic busy_a,
  output logic busy_b,
  output logic error
);

  localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic               start_a_q, start_a_d;
  logic               start_b_q, start_b_d;
  logic               tick_q, tick_d;
  logic [1:0]         busy_q, busy_d;
  logic               error_q, error_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] timer_next;

  logic [GAP_W-1:0]   gap_a, gap_b;
  logic               clr_gap_a, clr_gap_b, inc_gap;
  logic               elig_a, elig_b;
  logic               done_err;

  gap_counter #(.GAP_W(GAP_W), .RESET_VAL(MIN_GAP)) u_gap_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_gap_a),
    .inc   (inc_gap),
    .count (gap_a)
  );

  gap_counter #(.GAP_W(GAP_W), .RESET_VAL(MIN_GAP)) u_gap_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_gap_b),
    .inc   (inc_gap),
    .count (gap_b)
  );

  assign elig_a     = env_a & ~busy_q[TASK_A] & (gap_a >= GAP_W'(MIN_GAP));
  assign elig_b     = env_b & ~busy_q[TASK_B] & (gap_b >= GAP_W'(MIN_GAP));
  assign done_err   = (task_done_a & ~busy_q[TASK_A]) | (task_done_b & ~busy_q[TASK_B]);
  assign timer_next = timer_q + TIMER_W'(1);

  // Next-state and next-output decision. Pulses default low so each one lasts
  // exactly one cycle. Completions are handled in both live states; a done on
  // an idle machine overrides any release or tick that cycle and goes to ERR.
  always_comb begin
    state_d   = state_q;
    start_a_d = 1'b0;
    start_b_d = 1'b0;
    tick_d    = 1'b0;
    busy_d    = busy_q;
    error_d   = error_q;
    timer_d   = timer_q;
    clr_gap_a = 1'b0;
    clr_gap_b = 1'b0;
    inc_gap   = 1'b0;

    case (state_q)
      IDLE, WAIT_ACK: begin
        if (task_done_a) busy_d[TASK_A] = 1'b0;
        if (task_done_b) busy_d[TASK_B] = 1'b0;

        if (done_err) begin
          state_d = ERR;
          error_d = 1'b1;
        end else if (state_q == IDLE) begin
          if (elig_a) begin
            start_a_d      = 1'b1;
            busy_d[TASK_A] = 1'b1;
            clr_gap_a      = 1'b1;
            timer_d        = '0;
            state_d        = WAIT_ACK;
          end else if (elig_b) begin
            start_b_d      = 1'b1;
            busy_d[TASK_B] = 1'b1;
            clr_gap_b      = 1'b1;
            timer_d        = '0;
            state_d        = WAIT_ACK;
          end else if (env_tick) begin
            tick_d  = 1'b1;
            inc_gap = 1'b1;
          end
        end else begin
          // The ack may already arrive while the start pulse is still high.
          if (sched_ack) begin
            state_d = IDLE;
            timer_d = '0;
          end else if (timer_next == TIMER_W'(ACK_TIMEOUT)) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            timer_d = timer_next;
          end
        end
      end
      ERR: begin
        error_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs registered together; reset restores a clean IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_a_q <= 1'b0;
      start_b_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 2'b00;
      error_q   <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      start_a_q <= start_a_d;
      start_b_q <= start_b_d;
      tick_q    <= tick_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
      timer_q   <= timer_d;
    end
  end

  assign startA = start_a_q;
  assign startB = start_b_q;
  assign tick   = tick_q;
  assign busy_a = busy_q[TASK_A];
  assign busy_b = busy_q[TASK_B];
  assign error  = error_q;

endmodule

// File: tb/tb_sporadic_task_source.sv
// tb_sporadic_task_source
//   Directed bench for sporadic_task_source. Output vector under check is
//   {startA, startB, tick, busy_a, busy_b, error}.
module tb_sporadic_task_source;

  logic clk;
  logic rst_n;
  logic env_a, env_b, env_tick;
  logic sched_ack;
  logic task_done_a, task_done_b;
  logic startA, startB, tick, busy_a, busy_b, error;
  logic [5:0] outs;

  int vectors;
  int miscompares;

  sporadic_task_source dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .env_a       (env_a),
    .env_b       (env_b),
    .env_tick    (env_tick),
    .sched_ack   (sched_ack),
    .task_done_a (task_done_a),
    .task_done_b (task_done_b),
    .startA      (startA),
    .startB      (startB),
    .tick        (tick),
    .busy_a      (busy_a),
    .busy_b      (busy_b),
    .error       (error)
  );

  assign outs = {startA, startB, tick, busy_a, busy_b, error};

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    env_a       = 1'b0;
    env_b       = 1'b0;
    env_tick    = 1'b0;
    sched_ack   = 1'b0;
    task_done_a = 1'b0;
    task_done_b = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  // Reset clears every output and preloads both gap counters to 3.
  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    cycle();
    cycle();
    vectors++; if (outs !== 6'b000000) begin miscompares++; $display("[TB] FAIL reset_outs got=%b expected=%b", outs, 6'b000000); end
    vectors++; if (dut.gap_a !== 4'd3) begin miscompares++; $display("[TB] FAIL reset_gap_a got=%0d expected=3", dut.gap_a); end
    rst_n = 1'b1;
  endtask

  // Release A, ack in the pulse cycle, then release B to prove IDLE again.
  task automatic test_release_ack();
    do_reset();
    env_a = 1'b1;
    cycle();
    env_a = 1'b0;
    vectors++; if (outs !== 6'b100100) begin miscompares++; $display("[TB] FAIL rel_startA got=%b expected=%b", outs, 6'b100100); end
    sched_ack = 1'b1;
    cycle();
    sched_ack = 1'b0;
    vectors++; if (outs !== 6'b000100) begin miscompares++; $display("[TB] FAIL rel_after_ack got=%b expected=%b", outs, 6'b000100); end
    env_b = 1'b1;
    cycle();
    env_b = 1'b0;
    vectors++; if (outs !== 6'b010110) begin miscompares++; $display("[TB] FAIL rel_startB got=%b expected=%b", outs, 6'b010110); end
    sched_ack = 1'b1;
    cycle();
    sched_ack = 1'b0;
    task_done_a = 1'b1;
    task_done_b = 1'b1;
    cycle();
    clear_inputs();
    vectors++; if (outs !== 6'b000000) begin miscompares++; $display("[TB] FAIL rel_both_done got=%b expected=%b", outs, 6'b000000); end
  endtask

  // All three requests together: A wins; B follows once A is acked.
  task automatic test_priority();
    do_reset();
    env_a = 1'b1; env_b = 1'b1; env_tick = 1'b1;
    cycle();
    clear_inputs();
    vectors++; if (outs !== 6'b100100) begin miscompares++; $display("[TB] FAIL prio_A_wins got=%b expected=%b", outs, 6'b100100); end
    sched_ack = 1'b1;
    cycle();
    sched_ack = 1'b0;
    vectors++; if (outs !== 6'b000100) begin miscompares++; $display("[TB] FAIL prio_acked got=%b expected=%b", outs, 6'b000100); end
    env_b = 1'b1;
    cycle();
    env_b = 1'b0;
    vectors++; if (outs !== 6'b010110) begin miscompares++; $display("[TB] FAIL prio_B_only got=%b expected=%b", outs, 6'b010110); end
  endtask

  // Two ticks are not enough spacing for a second A; the third tick is.
  task automatic test_min_gap();
    do_reset();
    env_a = 1'b1;
    cycle();
    env_a = 1'b0;
    sched_ack = 1'b1;
    cycle();
    sched_ack = 1'b0;
    env_tick = 1'b1;
    cycle();
    vectors++; if (outs !== 6'b001100) begin miscompares++; $display("[TB] FAIL gap_tick1 got=%b expected=%b", outs, 6'b001100); end
    cycle();
    vectors++; if (outs !== 6'b001100) begin miscompares++; $display("[TB] FAIL gap_tick2 got=%b expected=%b", outs, 6'b001100); end
    env_tick = 1'b0;
    task_done_a = 1'b1;
    cycle();
    task_done_a = 1'b0;
    vectors++; if (outs !== 6'b000000) begin miscompares++; $display("[TB] FAIL gap_done_a got=%b expected=%b", outs, 6'b000000); end
    env_a = 1'b1;
    cycle();
    env_a = 1'b0;
    vectors++; if (outs !== 6'b000000) begin miscompares++; $display("[TB] FAIL gap_dropped got=%b expected=%b", outs, 6'b000000); end
    env_tick = 1'b1;
    cycle();
    env_tick = 1'b0;
    vectors++; if (outs !== 6'b001000) begin miscompares++; $display("[TB] FAIL gap_tick3 got=%b expected=%b", outs, 6'b001000); end
    env_a = 1'b1;
    cycle();
    env_a = 1'b0;
    vectors++; if (outs !== 6'b100100) begin miscompares++; $display("[TB] FAIL gap_release got=%b expected=%b", outs, 6'b100100); end
  endtask

  // Ack in the second WAIT_ACK cycle is still in time.
  task automatic test_ack_late();
    do_reset();
    env_b = 1'b1;
    cycle();
    env_b = 1'b0;
    cycle();
    vectors++; if (outs !== 6'b000010) begin miscompares++; $display("[TB] FAIL late_wait got=%b expected=%b", outs, 6'b000010); end
    sched_ack = 1'b1;
    cycle();
    sched_ack = 1'b0;
    vectors++; if (outs !== 6'b000010) begin miscompares++; $display("[TB] FAIL late_no_error got=%b expected=%b", outs, 6'b000010); end
  endtask

  // No ack for two cycles: sticky error, pulses suppressed until reset.
  task automatic test_ack_timeout();
    do_reset();
    env_b = 1'b1;
    cycle();
    env_b = 1'b0;
    vectors++; if (outs !== 6'b010010) begin miscompares++; $display("[TB] FAIL to_startB got=%b expected=%b", outs, 6'b010010); end
    cycle();
    vectors++; if (outs !== 6'b000010) begin miscompares++; $display("[TB] FAIL to_wait1 got=%b expected=%b", outs, 6'b000010); end
    cycle();
    vectors++; if (outs !== 6'b000011) begin miscompares++; $display("[TB] FAIL to_error got=%b expected=%b", outs, 6'b000011); end
    env_a = 1'b1; env_b = 1'b1; env_tick = 1'b1; sched_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      vectors++; if (outs !== 6'b000011) begin miscompares++; $display("[TB] FAIL to_err_hold%0d got=%b expected=%b", i, outs, 6'b000011); end
    end
    clear_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    vectors++; if (outs !== 6'b000000) begin miscompares++; $display("[TB] FAIL to_reset got=%b expected=%b", outs, 6'b000000); end
    env_a = 1'b1;
    cycle();
    env_a = 1'b0;
    vectors++; if (outs !== 6'b100100) begin miscompares++; $display("[TB] FAIL to_idle_again got=%b expected=%b", outs, 6'b100100); end
  endtask

  // Completion for a type that is not busy is a protocol error.
  task automatic test_spurious_done();
    do_reset();
    task_done_b = 1'b1;
    cycle();
    task_done_b = 1'b0;
    vectors++; if (outs !== 6'b000001) begin miscompares++; $display("[TB] FAIL spur_done_b got=%b expected=%b", outs, 6'b000001); end
  endtask

  // Twenty ticks in a row; gaps pin at 15 and A releases immediately after.
  task automatic test_tick_saturation();
    int ticks_seen;
    do_reset();
    ticks_seen = 0;
    env_tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (tick === 1'b1) ticks_seen++;
      vectors++; if (outs !== 6'b001000) begin miscompares++; $display("[TB] FAIL sat_tick%0d got=%b expected=%b", i, outs, 6'b001000); end
    end
    env_tick = 1'b0;
    vectors++; if (ticks_seen !== 20) begin miscompares++; $display("[TB] FAIL sat_tick_count got=%0d expected=20", ticks_seen); end
    vectors++; if (dut.gap_a !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_gap_a got=%0d expected=15", dut.gap_a); end
    vectors++; if (dut.gap_b !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_gap_b got=%0d expected=15", dut.gap_b); end
    env_a = 1'b1;
    cycle();
    env_a = 1'b0;
    vectors++; if (outs !== 6'b100100) begin miscompares++; $display("[TB] FAIL sat_release got=%b expected=%b", outs, 6'b100100); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear_inputs();
    test_reset();
    test_release_ack();
    test_priority();
    test_min_gap();
    test_ack_late();
    test_ack_timeout();
    test_spurious_done();
    test_tick_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
